fp_addsub_rne_seq: RTL
======================

// Module: fp_addsub_rne_seq
// PURPOSE
//  Parametrised multi-cycle IEEE-style floating-point adder/subtractor, successor to the 16-bit add/sub FSM.
//  Generic EXP_W/MAN_W fields, start/busy/done handshake, guard/round/sticky alignment,
//  round-to-nearest-even, sticky over/underflow flags. Sits in the FPU datapath beside mul/div units.
// PARAMETERS
//  EXP_W   5    exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W   10   stored fraction width (hidden bit implicit); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-high reset
//  start   in   1   launch operation; sampled only in IDLE
//  addSub  in   1   0 = X+Y, 1 = X-Y; latched with operands on start
//  X, Y    in   W   operands {sign, exp, frac}; latched on start
//  busy    out  1   high from cycle after accepted start until done cycle inclusive
//  done    out  1   one-cycle pulse: result/OFUF valid
//  result  out  W   packed result; held until next accepted start
//  OFUF    out  2   2'b10 overflow, 2'b01 underflow, 2'b00 normal; held with result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, OFUF=0. Reset mid-operation aborts, no done pulse.
//  Handshake: start in IDLE latches X,Y,addSub; start while busy ignored; done pulses 1 cycle, then IDLE.
//  Start may be asserted in the cycle after done (back-to-back).
//  Input classes: exp==0 -> zero (denormals flushed, sign kept); exp==all-ones -> out of range,
//   result {sX^..., all-ones, 0} with OFUF=2'b10, done via DONE state.
//  Effective Y sign = Y.sign ^ addSub.
//  States:
//   IDLE   -> UNPACK on start.
//   UNPACK: decode classes; any zero operand -> DONE with other operand (Y sign-flipped if addSub),
//           both zero -> +0 (or -0 only if both effective signs negative); else -> ALIGN.
//   ALIGN:  one right shift of smaller-exponent mantissa per cycle into {hidden,frac,G,R,S};
//           shifted-out bits OR into S. If exp diff > MAN_W+2, collapse to S=1 in one cycle.
//           Equal exponents -> ADD.
//   ADD:    same sign: add; else larger-magnitude minus smaller, sign of larger; width MAN_W+5 (carry).
//           Exact zero -> +0, DONE.
//   NORM:   carry set -> one right shift (S keeps OR), exp+1; else left shift one per cycle until hidden=1,
//           exp-1 each. Exp reaching 0 while unnormalised -> underflow.
//   ROUND:  RNE: increment if G&(R|S|lsb). Mantissa carry-out -> shift right, exp+1.
//           Exp == all-ones after NORM/ROUND -> overflow.
//   DONE:   drive result/OFUF, done=1 -> IDLE.
//  Overflow: result {sign, all-ones, 0}, OFUF=2'b10. Underflow: result {sign, 0, 0}, OFUF=2'b01.
//  Latency: accepted start to done <= 2*MAN_W+10 cycles; zero-operand path exactly 3 cycles.
// STRUCTURE
//  Shared package fp_pkg: state encoding, OFUF code constants, field-width/bias localparams.
//  One sub-module: fp_rne_round (combinational GRS round + pack + exponent overflow check).
// TESTING  (EXP_W=5, MAN_W=10)
//  X=0x3C00,Y=0x3C00,addSub=0 -> result 0x4000, OFUF 00.
//  X=0x3C00,Y=0x4000,addSub=1 -> 0xBC00; X=0x3C00,Y=0x3C00,addSub=1 -> 0x0000.
//  RNE ties: 0x3C00+0x1000 -> 0x3C00; 0x3C01+0x1000 -> 0x3C02.
//  0x7BFF+0x7BFF -> 0x7C00, OFUF 10; 0x0401-0x0400 -> 0x0000, OFUF 01.
//  Zero bypass: X=0,Y=0x4200,addSub=1 -> 0xC200 after 3 cycles; start while busy ignored.
//  Reset pulse during ALIGN -> busy/done/result/OFUF 0; next start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub unit: default field widths,
// FSM state encoding and the over/underflow flag codes.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 5;
    localparam int unsigned MAN_W_DEF = 10;
    localparam int unsigned BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

    localparam logic [1:0] OFUF_NONE  = 2'b00;
    localparam logic [1:0] OFUF_OVER  = 2'b10;
    localparam logic [1:0] OFUF_UNDER = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalised {hidden, frac, G, R, S} mantissa, then
// pack the word and flag exponent overflow.
module fp_rne_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   sign,
    input  logic [EXP_W-1:0]       exp,
    input  logic [MAN_W+3:0]       man,
    output logic [EXP_W+MAN_W:0]   result_c,
    output logic [1:0]             ofuf_c
);

    localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'((1 << EXP_W) - 1);

    logic                 inc;
    logic [MAN_W+1:0]     rounded;
    logic [EXP_W:0]       exp_adj;
    logic [MAN_W-1:0]     frac;

    always_comb begin
        inc      = man[2] & (man[1] | man[0] | man[3]);
        rounded  = {1'b0, man[MAN_W+3:3]} + (MAN_W+2)'(inc);
        // Rounding carry-out leaves 10.00..0: renormalise by one and bump the exponent
        exp_adj  = {1'b0, exp} + (EXP_W+1)'(rounded[MAN_W+1]);
        frac     = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        result_c = {sign, exp_adj[EXP_W-1:0], frac};
        ofuf_c   = OFUF_NONE;
        if (exp_adj >= EXP_MAX) begin
            result_c = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ofuf_c   = OFUF_OVER;
        end
    end

endmodule

// File: rtl/fp_addsub_rne_seq.sv
// Multi-cycle floating-point adder/subtractor: one alignment or normalisation
// shift per cycle, guard/round/sticky tracking and RNE rounding.
module fp_addsub_rne_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   addSub,
    input  logic [EXP_W+MAN_W:0]   X,
    input  logic [EXP_W+MAN_W:0]   Y,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [1:0]             OFUF
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned M  = MAN_W + 4;
    localparam int unsigned SW = MAN_W + 5;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W:0]   COLLAPSE = (EXP_W+1)'(MAN_W + 2);

    state_t           state, state_nxt;
    logic             busy_nxt, done_nxt;
    logic [W-1:0]     result_nxt;
    logic [1:0]       ofuf_nxt;

    logic             sx, sx_nxt, sy, sy_nxt, sr, sr_nxt;
    logic [EXP_W-1:0] ex, ex_nxt, ey, ey_nxt, er, er_nxt, diff;
    logic [M-1:0]     mx, mx_nxt, my, my_nxt;
    logic [SW-1:0]    mr, mr_nxt, sum;
    logic [W-1:0]     res_q, res_nxt, rnd_result_c;
    logic [1:0]       ofq, ofq_nxt, rnd_ofuf_c;

    fp_rne_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign     (sr),
        .exp      (er),
        .man      (mr[M-1:0]),
        .result_c (rnd_result_c),
        .ofuf_c   (rnd_ofuf_c)
    );

    // State, output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            OFUF   <= OFUF_NONE;
            sx     <= 1'b0;
            sy     <= 1'b0;
            sr     <= 1'b0;
            ex     <= '0;
            ey     <= '0;
            er     <= '0;
            mx     <= '0;
            my     <= '0;
            mr     <= '0;
            res_q  <= '0;
            ofq    <= OFUF_NONE;
        end else begin
            state  <= state_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            result <= result_nxt;
            OFUF   <= ofuf_nxt;
            sx     <= sx_nxt;
            sy     <= sy_nxt;
            sr     <= sr_nxt;
            ex     <= ex_nxt;
            ey     <= ey_nxt;
            er     <= er_nxt;
            mx     <= mx_nxt;
            my     <= my_nxt;
            mr     <= mr_nxt;
            res_q  <= res_nxt;
            ofq    <= ofq_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        result_nxt = result;
        ofuf_nxt   = OFUF;
        sx_nxt     = sx;
        sy_nxt     = sy;
        sr_nxt     = sr;
        ex_nxt     = ex;
        ey_nxt     = ey;
        er_nxt     = er;
        mx_nxt     = mx;
        my_nxt     = my;
        mr_nxt     = mr;
        res_nxt    = res_q;
        ofq_nxt    = ofq;
        sum        = '0;
        diff       = (ex > ey) ? ex - ey : ey - ex;

        case (state)
            S_IDLE: begin
                // busy still covers the done cycle, so a start held there is ignored
                if (start && !busy) begin
                    sx_nxt    = X[W-1];
                    ex_nxt    = X[W-2:MAN_W];
                    mx_nxt    = {1'b1, X[MAN_W-1:0], 3'b000};
                    sy_nxt    = Y[W-1] ^ addSub;
                    ey_nxt    = Y[W-2:MAN_W];
                    my_nxt    = {1'b1, Y[MAN_W-1:0], 3'b000};
                    state_nxt = S_UNPACK;
                end
            end

            S_UNPACK: begin
                ofq_nxt   = OFUF_NONE;
                state_nxt = S_DONE;
                if (ex == EXP_ONES || ey == EXP_ONES) begin
                    res_nxt = {(ex == EXP_ONES) ? sx : sy, EXP_ONES, {MAN_W{1'b0}}};
                    ofq_nxt = OFUF_OVER;
                end else if (ex == EXP_ZERO && ey == EXP_ZERO) begin
                    res_nxt = {sx & sy, {(W-1){1'b0}}};
                end else if (ex == EXP_ZERO) begin
                    res_nxt = {sy, ey, my[M-2:3]};
                end else if (ey == EXP_ZERO) begin
                    res_nxt = {sx, ex, mx[M-2:3]};
                end else begin
                    state_nxt = S_ALIGN;
                end
            end

            S_ALIGN: begin
                // Far-apart exponents only ever contribute a sticky bit
                if (ex == ey) begin
                    state_nxt = S_ADD;
                end else if (ex > ey) begin
                    if ({1'b0, diff} > COLLAPSE) begin
                        my_nxt = M'(1);
                        ey_nxt = ex;
                    end else begin
                        my_nxt = {1'b0, my[M-1:2], my[1] | my[0]};
                        ey_nxt = ey + EXP_W'(1);
                    end
                end else begin
                    if ({1'b0, diff} > COLLAPSE) begin
                        mx_nxt = M'(1);
                        ex_nxt = ey;
                    end else begin
                        mx_nxt = {1'b0, mx[M-1:2], mx[1] | mx[0]};
                        ex_nxt = ex + EXP_W'(1);
                    end
                end
            end

            S_ADD: begin
                if (sx == sy) begin
                    sum    = {1'b0, mx} + {1'b0, my};
                    sr_nxt = sx;
                end else if (mx >= my) begin
                    sum    = {1'b0, mx} - {1'b0, my};
                    sr_nxt = sx;
                end else begin
                    sum    = {1'b0, my} - {1'b0, mx};
                    sr_nxt = sy;
                end
                mr_nxt = sum;
                er_nxt = ex;
                if (sum == '0) begin
                    res_nxt   = '0;
                    ofq_nxt   = OFUF_NONE;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_NORM;
                end
            end

            S_NORM: begin
                if (mr[SW-1]) begin
                    mr_nxt    = {1'b0, mr[SW-1:2], mr[1] | mr[0]};
                    er_nxt    = er + EXP_W'(1);
                    state_nxt = S_ROUND;
                end else if (!mr[SW-2]) begin
                    // Denormals are flushed: running out of exponent is an underflow
                    if (er <= EXP_W'(1)) begin
                        res_nxt   = {sr, {(W-1){1'b0}}};
                        ofq_nxt   = OFUF_UNDER;
                        state_nxt = S_DONE;
                    end else begin
                        mr_nxt = {mr[SW-2:0], 1'b0};
                        er_nxt = er - EXP_W'(1);
                    end
                end else begin
                    state_nxt = S_ROUND;
                end
            end

            S_ROUND: begin
                res_nxt   = rnd_result_c;
                ofq_nxt   = rnd_ofuf_c;
                state_nxt = S_DONE;
            end

            S_DONE: begin
                done_nxt   = 1'b1;
                result_nxt = res_q;
                ofuf_nxt   = ofq;
                state_nxt  = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE) || (state == S_DONE);
    end

endmodule
